mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single-ported unified memory shared by the pipelined MIPS core's instruction-fetch (IF) stage and data-memory (MEM) stage. It accepts one request at a time from either port and drives the memory for a fixed latency. It returns read data with a one-cycle acknowledge and publishes the port-select that steers the shared memory address/data path. Data accesses have priority, with a bounded-streak rule so that fetch cannot starve.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_port_arbiter_mux.sv | 14 +
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM unified-memory arbiter.
// Imported by the arbiter top and its bench.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Generic 2:1 multiplexer used to steer the shared memory address path.
// sel = 0 picks a, sel = 1 picks b.
module mux #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single-ported memory shared by IF and MEM.
// Data has priority; a bounded streak counter lets a waiting fetch in.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_LATENCY     = 2,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic                  mem_sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] LAT_LOAD =
    CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] STREAK_MAX =
    CNT_W'(MAX_DATA_STREAK);

  state_t state, nstate;

  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      streak;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] ia_q;
  logic [ADDR_WIDTH-1:0] da_q;
  logic                  grant;
  logic                  grant_d;
  logic                  last;

  assign busy = (state != IDLE);
  assign last = (state == ACCESS) && (cnt == '0);

  always_comb begin
    nstate  = state;
    grant   = 1'b0;
    grant_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (if_req || d_req) begin
          grant   = 1'b1;
          grant_d = d_req &&
                    !(if_req && streak == STREAK_MAX);
          nstate  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) nstate = DONE;
      end
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_sel   <= OWNER_IF;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      ia_q      <= '0;
      da_q      <= '0;
      we_q      <= 1'b0;
      cnt       <= '0;
      streak    <= '0;
    end else begin
      if_ack <= last && (mem_sel == OWNER_IF);
      d_ack  <= last && (mem_sel == OWNER_D);
      mem_en <= (nstate == ACCESS);
      mem_we <= (nstate == ACCESS) &&
                (grant ? (grant_d && d_we) : we_q);
      if (grant) begin
        mem_sel   <= grant_d ? OWNER_D : OWNER_IF;
        ia_q      <= if_addr;
        da_q      <= d_addr;
        we_q      <= grant_d && d_we;
        mem_wdata <= d_wdata;
        cnt       <= LAT_LOAD;
        // only data wins that keep a fetch waiting extend the streak
        if (grant_d && if_req) begin
          if (streak != STREAK_MAX)
            streak <= streak + 1'b1;
        end else begin
          streak <= '0;
        end
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (last && !we_q) begin
        if (mem_sel == OWNER_D) d_rdata  <= mem_rdata;
        else                    if_rdata <= mem_rdata;
      end
    end
  end

  mux #(
    .DATA_WIDTH(ADDR_WIDTH)
  ) u_addr_mux (
    .sel(mem_sel),
    .a  (ia_q),
    .b  (da_q),
    .y  (mem_addr)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model,
// directed scenarios, random traffic and a latency sweep.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 2;
  localparam int S  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_ack, d_req, d_we, d_ack;
  logic          mem_en, mem_we, mem_sel, busy;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_init;
  logic [DW-1:0] tbmem [256];

  logic          sw_req [2];
  logic [AW-1:0] sw_a [2];
  logic          sw_ack [2];
  logic [DW-1:0] sw_rd [2];
  logic          sw_dack [2];
  logic [DW-1:0] sw_drd [2];
  logic          sw_en [2];
  logic          sw_we [2];
  logic          sw_sel [2];
  logic [AW-1:0] sw_maddr [2];
  logic [DW-1:0] sw_mwd [2];
  logic [DW-1:0] sw_mrd [2];
  logic          sw_busy [2];

  int checks = 0;
  int errors = 0;
  int t = 0;

  // transaction-level model state
  bit            act;
  int            g;
  logic          m_own, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_streak;
  logic [DW-1:0] e_if_rd, e_d_rd;
  logic [DW-1:0] mm [256];
  bit            ackq [$];

  // requester agents
  bit saw_if, saw_d;
  bit if_hold, d_hold, rnd_mode;
  int if_rate, d_rate, if_wait, d_wait;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 16) return 32'h8C220004;
    return 32'(i) * 32'h01000193 + 32'h0BAD0000;
  endfunction

  function automatic logic [DW-1:0] fw(input logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    return {22'd0, 8'($urandom_range(255)), 2'b00};
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) tbmem[i] <= init_word(i);
    end else if (mem_en && mem_we) begin
      tbmem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  assign mem_rdata = tbmem[mem_addr[9:2]];

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MEM_LATENCY(L), .MAX_DATA_STREAK(S)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  for (genvar k = 0; k < 2; k++) begin : g_sw
    mem_port_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .MEM_LATENCY(k == 0 ? 1 : 15), .MAX_DATA_STREAK(S)
    ) u_dut (
      .clk(clk), .rst(rst),
      .if_req(sw_req[k]), .if_addr(sw_a[k]),
      .if_ack(sw_ack[k]), .if_rdata(sw_rd[k]),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0),
      .d_wdata(32'd0), .d_ack(sw_dack[k]), .d_rdata(sw_drd[k]),
      .mem_en(sw_en[k]), .mem_we(sw_we[k]), .mem_sel(sw_sel[k]),
      .mem_addr(sw_maddr[k]), .mem_wdata(sw_mwd[k]),
      .mem_rdata(sw_mrd[k]), .busy(sw_busy[k])
    );
    assign sw_mrd[k] = fw(sw_maddr[k]);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    logic e_ifa, e_da, e_en, e_we, e_busy, d;
    int ph;
    e_ifa = 0; e_da = 0; e_en = 0; e_we = 0; e_busy = 0;
    saw_if = if_ack;
    saw_d  = d_ack;
    if (if_ack) ackq.push_back(1'b0);
    if (d_ack)  ackq.push_back(1'b1);
    chk("if_rdata", 64'(if_rdata), 64'(e_if_rd));
    chk("d_rdata", 64'(d_rdata), 64'(e_d_rd));
    if (act) begin
      ph = t - g;
      e_busy = 1;
      if (ph <= L) begin
        e_en = 1;
        e_we = m_we;
        chk("mem_sel", 64'(mem_sel), 64'(m_own));
        chk("mem_addr", 64'(mem_addr), 64'(m_addr));
        if (m_we) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        if (ph == L && !m_we) begin
          if (m_own) e_d_rd  = mm[m_addr[9:2]];
          else       e_if_rd = mm[m_addr[9:2]];
        end
      end else begin
        e_ifa = !m_own;
        e_da  = m_own;
        act   = 0;
      end
    end else if (!rst && (if_req || d_req)) begin
      d = d_req && !(if_req && m_streak == S);
      if (d && if_req) m_streak = (m_streak < S) ? m_streak + 1 : S;
      else             m_streak = 0;
      act     = 1;
      g       = t;
      m_own   = d;
      m_we    = d && d_we;
      m_addr  = d ? d_addr : if_addr;
      m_wdata = d_wdata;
      if (m_we) mm[d_addr[9:2]] = d_wdata;
    end
    chk("ctl", 64'({if_ack, d_ack, mem_en, mem_we, busy}),
        64'({e_ifa, e_da, e_en, e_we, e_busy}));
  endtask

  task automatic agents();
    if (if_req) begin
      if_wait++;
      if (saw_if) begin
        if_wait = 0;
        if (if_hold || (rnd_mode && $urandom_range(3) == 0))
          if_addr = rnd_addr();
        else
          if_req = 1'b0;
      end else if (if_wait > 200) begin
        chk("if_timeout", 64'(if_wait), 64'd0);
        if_req = 1'b0; if_wait = 0;
      end
    end else if (int'($urandom_range(99)) < if_rate) begin
      if_req = 1'b1; if_addr = rnd_addr();
    end
    if (d_req) begin
      d_wait++;
      if (saw_d) begin
        d_wait = 0;
        if (d_hold || (rnd_mode && $urandom_range(3) == 0)) begin
          d_addr = rnd_addr(); d_we = 1'($urandom_range(1));
          d_wdata = $urandom;
        end else begin
          d_req = 1'b0;
        end
      end else if (d_wait > 200) begin
        chk("d_timeout", 64'(d_wait), 64'd0);
        d_req = 1'b0; d_wait = 0;
      end
    end else if (int'($urandom_range(99)) < d_rate) begin
      d_req = 1'b1; d_addr = rnd_addr();
      d_we = 1'($urandom_range(1)); d_wdata = $urandom;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    t++;
    agents();
  endtask

  task automatic drain();
    int n = 0;
    while ((if_req || d_req || act) && n < 200) begin
      step();
      n++;
    end
    chk("drain", 64'(n < 200), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int qs;
    int nxt [2];
    bit upd [2];
    logic [5:0] starve_pat;
    rst = 1'b1; mem_init = 1'b1;
    if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    sw_req[0] = 0; sw_req[1] = 0;
    sw_a[0] = '0; sw_a[1] = '0;
    act = 0; m_streak = 0; e_if_rd = '0; e_d_rd = '0;
    if_hold = 0; d_hold = 0; rnd_mode = 0;
    if_rate = 0; d_rate = 0; if_wait = 0; d_wait = 0;
    for (int i = 0; i < 256; i++) mm[i] = init_word(i);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", 64'({if_ack, d_ack, mem_en, mem_we, mem_sel, busy}), 64'd0);
    chk("reset_data", 64'(mem_addr | mem_wdata | if_rdata | d_rdata), 64'd0);
    mem_init = 1'b0;
    rst = 1'b0;
    t = 0;

    // single IF read
    if_req = 1; if_addr = 32'h40;
    repeat (L + 3) step();
    chk("if_read_0x40", 64'(if_rdata), 64'h8C220004);

    // data write
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    repeat (L + 3) step();
    chk("d_write_mem", 64'(tbmem[64]), 64'hDEADBEEF);
    chk("d_write_rdata", 64'(d_rdata), 64'd0);

    // simultaneous requests: data first, IF next
    qs = ackq.size();
    if_req = 1; if_addr = 32'h100;
    d_req = 1; d_we = 0; d_addr = 32'h40;
    drain();
    chk("simul_order", 64'({ackq[qs], ackq[qs + 1]}), 64'b10);
    chk("simul_if_sees_write", 64'(if_rdata), 64'hDEADBEEF);

    // starvation: both held continuously
    qs = ackq.size();
    if_hold = 1; d_hold = 1;
    if_req = 1; if_addr = rnd_addr();
    d_req = 1; d_we = 0; d_addr = rnd_addr();
    repeat (28) step();
    if_hold = 0; d_hold = 0;
    drain();
    starve_pat = 6'b101111;
    chk("starve_cnt", 64'(ackq.size() - qs >= 6), 64'd1);
    if (ackq.size() - qs >= 6)
      for (int i = 0; i < 6; i++)
        chk("starve_seq", 64'(ackq[qs + i]), 64'(starve_pat[i]));

    // reset in the middle of ACCESS
    if_req = 1; if_addr = 32'h40;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_ctl", 64'({if_ack, d_ack, mem_en, mem_we, mem_sel, busy}), 64'd0);
    chk("rst_mid_data", 64'(mem_addr | mem_wdata | if_rdata | d_rdata), 64'd0);
    if_req = 0; if_wait = 0;
    act = 0; m_streak = 0; e_if_rd = '0; e_d_rd = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    t++;
    qs = ackq.size();
    repeat (3) step();
    chk("rst_no_ack", 64'(ackq.size() - qs), 64'd0);
    if_req = 1; if_addr = 32'h40;
    drain();
    chk("rst_recover_ack", 64'(ackq.size() - qs), 64'd1);
    chk("rst_recover_data", 64'(if_rdata), 64'h8C220004);

    // random traffic
    rnd_mode = 1; if_rate = 25; d_rate = 25;
    repeat (1500) step();
    rnd_mode = 0; if_rate = 0; d_rate = 0;
    drain();

    // latency sweep: back-to-back IF at MEM_LATENCY 1 and 15
    for (int k = 0; k < 2; k++) begin
      sw_req[k] = 1;
      sw_a[k] = rnd_addr();
      nxt[k] = t + ((k == 0) ? 1 : 15) + 1;
      upd[k] = 0;
    end
    repeat (110) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("sw_ack", 64'(sw_ack[k]), 64'(t == nxt[k]));
        if (t == nxt[k]) begin
          chk("sw_rdata", 64'(sw_rd[k]), 64'(fw(sw_a[k])));
          chk("sw_side", 64'({sw_dack[k], sw_we[k], sw_sel[k],
              sw_busy[k], sw_en[k]}), 64'b00010);
          chk("sw_zero", 64'(sw_drd[k] | sw_mwd[k]), 64'd0);
          nxt[k] = nxt[k] + ((k == 0) ? 1 : 15) + 2;
          upd[k] = 1;
        end
      end
      @(posedge clk);
      #1;
      t++;
      for (int k = 0; k < 2; k++)
        if (upd[k]) begin
          sw_a[k] = rnd_addr();
          upd[k] = 0;
        end
    end
    sw_req[0] = 0; sw_req[1] = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
